// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter that shares one 4-digit BCD RNG between NUM_REQ requesters.
// Each grant issues one fetch strobe, captures sanitised digits and returns them with a done pulse.
module rng_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MIN_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] done,
    output logic [ID_W-1:0]    grant_id,
    output logic               num_valid,
    output logic [15:0]        num_data,
    output logic [15:0]        fetch_count,
    output logic               fetch_num,
    input  logic [3:0]         rng_d1000,
    input  logic [3:0]         rng_d100,
    input  logic [3:0]         rng_d10,
    input  logic [3:0]         rng_d1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_DELIVER,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic               fetch_q, fetch_d;
    logic               valid_q, valid_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [15:0]        data_q, data_d;
    logic [15:0]        fetch_count_q, fetch_count_d;
    logic [3:0]         gap_q, gap_d;

    logic               pickFound;
    logic [ID_W-1:0]    pickIdx;
    logic [ID_W-1:0]    candidate;

    // Non-BCD digits from the RNG are clamped to 9 so consumers always see valid BCD.
    function automatic logic [3:0] satDigit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        candidate = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            candidate = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!pickFound && req[candidate]) begin
                pickFound = 1'b1;
                pickIdx   = candidate;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        fetch_d       = 1'b0;
        valid_d       = 1'b0;
        done_d        = '0;
        data_d        = data_q;
        fetch_count_d = fetch_count_q;
        gap_d         = gap_q;
        case (state_q)
            S_IDLE: begin
                if (pickFound) begin
                    grant_d = pickIdx;
                    ptr_d   = pickIdx;
                    fetch_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_count_d = fetch_count_q + 16'd1;
                state_d       = S_CAPTURE;
            end
            S_CAPTURE: begin
                data_d = {satDigit(rng_d1000), satDigit(rng_d100),
                          satDigit(rng_d10), satDigit(rng_d1)};
                // A requester that let go of req before capture forfeits this number.
                if (req[grant_q]) begin
                    valid_d = 1'b1;
                    done_d  = NUM_REQ'(1) << grant_q;
                end
                state_d = S_DELIVER;
            end
            S_DELIVER: begin
                gap_d   = 4'd0;
                state_d = (MIN_GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_q == 4'(MIN_GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= ID_W'(NUM_REQ - 1);
            grant_q       <= '0;
            fetch_q       <= 1'b0;
            valid_q       <= 1'b0;
            done_q        <= '0;
            data_q        <= '0;
            fetch_count_q <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            fetch_q       <= fetch_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            data_q        <= data_d;
            fetch_count_q <= fetch_count_d;
            gap_q         <= gap_d;
        end
    end

    assign done        = done_q;
    assign grant_id    = grant_q;
    assign num_valid   = valid_q;
    assign num_data    = data_q;
    assign fetch_count = fetch_count_q;
    assign fetch_num   = fetch_q;

endmodule
